// File: rtl/ym3438_pg_if.sv
// Slot-rate bus between the LFO/PM stage and the YM3438 phase generator.
// The master drives per-slot operator parameters. The slave (phase generator) returns the
// operator phase and the stage-B increment.
interface ym3438_pg_if;
  logic        c1;
  logic [11:0] fnum_lfo;
  logic [2:0]  block;
  logic [3:0]  multi;
  logic [2:0]  dt;
  logic [4:0]  dt_mag;
  logic        pg_reset;
  logic [9:0]  pg_out;
  logic [19:0] pg_inc_dbg;

  modport master (
    output c1, fnum_lfo, block, multi, dt, dt_mag, pg_reset,
    input  pg_out, pg_inc_dbg
  );

  modport slave (
    input  c1, fnum_lfo, block, multi, dt, dt_mag, pg_reset,
    output pg_out, pg_inc_dbg
  );
endinterface

// File: rtl/ym3438_pg.sv
// YM3438 phase generator.
// The pipeline has three stages:
//   A: block shift, then optional detune.
//   B: multiplier.
//   C: phase accumulate into a circulating ring of SLOTS 20-bit phases.
// Define YM_PG_DETUNE_EN to build the detune adder. Without it, dt and dt_mag are ignored.
module ym3438_pg #(
  parameter int unsigned SLOTS = 24
) (
  input logic        MCLK,
  input logic        IC,
  ym3438_pg_if.slave bus
);

  logic [18:0] shifted;
  logic [16:0] base;
  logic [16:0] det;
  logic [19:0] mul;
  logic [19:0] inc_d;
  logic [19:0] p_new;

  logic [16:0] det_q;
  logic [3:0]  multi_q;
  logic        rst_a_q;
  logic [19:0] inc_q;
  logic        rst_b_q;
  logic [19:0] ring_q [SLOTS];
  logic [9:0]  pg_out_q;

  // Stage A combinational: octave shift and detune for the slot on the bus.
  always_comb begin
    // 0xFFF << 7 needs 19 bits. The shift is done wide, then truncated after >> 2.
    shifted = {7'b0, bus.fnum_lfo} << bus.block;
    base    = 17'(shifted >> 2);
    det     = base;
`ifdef YM_PG_DETUNE_EN
    if (bus.dt[1:0] != 2'b00) begin
      // Wraps mod 2^17. Real chip behaviour, no saturation.
      det = bus.dt[2] ? (base - {12'b0, bus.dt_mag}) : (base + {12'b0, bus.dt_mag});
    end
`endif
  end

`ifndef YM_PG_DETUNE_EN
  logic unused_dt;
  assign unused_dt = ^{bus.dt, bus.dt_mag};
`endif

  // Stage B and accumulate combinational: multiplier, then phase sum at the ring head.
  always_comb begin
    mul   = {3'b0, det_q} * {16'b0, multi_q};
    inc_d = (multi_q == 4'd0) ? {4'b0, det_q[16:1]} : mul;
    p_new = rst_b_q ? 20'h0 : (ring_q[SLOTS-1] + inc_q);
  end

  // All pipeline and ring state advances one slot per c1 edge. Reset overrides c1.
  always_ff @(posedge MCLK) begin
    if (!IC) begin
      det_q    <= '0;
      multi_q  <= '0;
      rst_a_q  <= 1'b0;
      inc_q    <= '0;
      rst_b_q  <= 1'b0;
      pg_out_q <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        ring_q[i] <= '0;
      end
    end else if (bus.c1) begin
      det_q    <= det;
      multi_q  <= bus.multi;
      rst_a_q  <= bus.pg_reset;
      inc_q    <= inc_d;
      rst_b_q  <= rst_a_q;
      pg_out_q <= p_new[19:10];
      // The tail is written here and read back at the head SLOTS edges later.
      ring_q[0] <= p_new;
      for (int i = 1; i < SLOTS; i++) begin
        ring_q[i] <= ring_q[i-1];
      end
    end
  end

  assign bus.pg_out     = pg_out_q;
  assign bus.pg_inc_dbg = inc_q;

endmodule

// File: tb/tb_ym3438_pg.sv
// Directed self-checking bench for ym3438_pg. A per-slot phase model tracks expected pg_out.
module tb_ym3438_pg;

  logic MCLK = 1'b0;
  logic IC;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [9:0] seen_out [256];

  ym3438_pg_if bus ();

  ym3438_pg #(
    .SLOTS (24)
  ) dut (
    .MCLK (MCLK),
    .IC   (IC),
    .bus  (bus)
  );

  always #5 MCLK = ~MCLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic set_in(input logic [11:0] fnum, input logic [2:0] blk, input logic [3:0] mul,
                        input logic [2:0] dtv, input logic [4:0] dtm);
    bus.fnum_lfo = fnum;
    bus.block    = blk;
    bus.multi    = mul;
    bus.dt       = dtv;
    bus.dt_mag   = dtm;
  endtask

  task automatic pulse_reset(input logic c1v);
    bus.c1       = c1v;
    bus.pg_reset = 1'b0;
    IC           = 1'b0;
    tick();
    IC     = 1'b1;
    bus.c1 = 1'b1;
  endtask

  // Feeds n slots of constant inputs after a reset. Input t has slot t % 24.
  // Its increment is visible one edge later and its pg_out two edges later.
  // ko_t selects the input index that asserts pg_reset (-1 for none).
  task automatic run_slots(input string tag, input int n, input logic [19:0] inc_exp,
                           input int ko_t);
    logic [19:0] ph [24];
    int s;
    for (int i = 0; i < 24; i++) ph[i] = 20'h0;
    for (int k = 0; k < n + 2; k++) begin
      bus.pg_reset = (k == ko_t);
      tick();
      check_eq({tag, "_inc"}, {12'b0, bus.pg_inc_dbg}, (k >= 1) ? {12'b0, inc_exp} : 32'h0);
      if (k >= 2) begin
        s = (k - 2) % 24;
        ph[s] = ((k - 2) == ko_t) ? 20'h0 : (ph[s] + inc_exp);
        check_eq({tag, "_out"}, {22'b0, bus.pg_out}, {22'b0, ph[s][19:10]});
        if (k - 2 < 256) seen_out[k-2] = bus.pg_out;
      end else begin
        check_eq({tag, "_out_fill"}, {22'b0, bus.pg_out}, 32'h0);
      end
    end
    bus.pg_reset = 1'b0;
  endtask

  initial begin
    IC           = 1'b0;
    bus.c1       = 1'b0;
    bus.pg_reset = 1'b0;
    set_in(12'h0, 3'd0, 4'd0, 3'd0, 5'd0);
    tick();
    tick();
    IC = 1'b1;

    // Random traffic leaves the ring non-zero. A reset taken while c1 is low must clear it.
    for (int i = 0; i < 60; i++) begin
      bus.c1       = 1'($urandom_range(0, 1));
      bus.pg_reset = 1'($urandom_range(0, 1));
      set_in(12'($urandom), 3'($urandom), 4'($urandom), 3'($urandom), 5'($urandom));
      tick();
    end
    pulse_reset(1'b0);
    check_eq("rst_out", {22'b0, bus.pg_out}, 32'h0);
    check_eq("rst_inc", {12'b0, bus.pg_inc_dbg}, 32'h0);
    set_in(12'h000, 3'd0, 4'd1, 3'd0, 5'd0);
    run_slots("rst_zero", 48, 20'h0, -1);

    // Basic increment: 0x400 << 4 >> 2 = 0x1000. After three frames the phase is 0x3000.
    pulse_reset(1'b1);
    set_in(12'h400, 3'd4, 4'd1, 3'd0, 5'd0);
    run_slots("basic", 72, 20'h01000, -1);
    check_eq("basic_3fr", {22'b0, bus.pg_out}, 32'h00C);

    // With c1 low, everything holds even while the inputs change.
    bus.c1 = 1'b0;
    set_in(12'hABC, 3'd7, 4'd9, 3'd3, 5'd17);
    bus.pg_reset = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_eq("hold_out", {22'b0, bus.pg_out}, 32'h00C);
    check_eq("hold_inc", {12'b0, bus.pg_inc_dbg}, 32'h01000);
    bus.pg_reset = 1'b0;

    // A multiplier of 0 gives half the base increment.
    pulse_reset(1'b1);
    set_in(12'h400, 3'd4, 4'd0, 3'd0, 5'd0);
    run_slots("multi0", 48, 20'h00800, -1);

    // Negative detune (sign set, magnitude select 1).
    pulse_reset(1'b1);
    set_in(12'h400, 3'd4, 4'd1, 3'b101, 5'd5);
`ifdef YM_PG_DETUNE_EN
    run_slots("det_neg", 48, 20'h00FFB, -1);
`else
    run_slots("det_neg", 48, 20'h01000, -1);
`endif

    // Positive detune.
    pulse_reset(1'b1);
    set_in(12'h400, 3'd4, 4'd1, 3'b001, 5'd5);
`ifdef YM_PG_DETUNE_EN
    run_slots("det_pos", 24, 20'h01005, -1);
`else
    run_slots("det_pos", 24, 20'h01000, -1);
`endif

    // Magnitude select 0 disables detune even with the sign set.
    pulse_reset(1'b1);
    set_in(12'h400, 3'd4, 4'd1, 3'b100, 5'd31);
    run_slots("det_off", 24, 20'h01000, -1);

    // Key-on at slot 5 in frame 4 (input index 101). Its neighbours keep accumulating.
    pulse_reset(1'b1);
    set_in(12'h400, 3'd4, 4'd1, 3'd0, 5'd0);
    run_slots("keyon", 144, 20'h01000, 101);
    check_eq("keyon_pre",  {22'b0, seen_out[77]},  32'h010);
    check_eq("keyon_hit",  {22'b0, seen_out[101]}, 32'h000);
    check_eq("keyon_next", {22'b0, seen_out[125]}, 32'h004);
    check_eq("keyon_nbr",  {22'b0, seen_out[102]}, 32'h014);
    check_eq("keyon_last", {22'b0, bus.pg_out},    32'h018);

    // Wrap: base 0x1FFE0 * 15 truncated to 20 bits; two frames wrap the phase mod 2^20.
    pulse_reset(1'b1);
    set_in(12'hFFF, 3'd7, 4'd15, 3'd0, 5'd0);
    run_slots("wrap", 48, 20'hDFE20, -1);
    check_eq("wrap_2fr", {22'b0, bus.pg_out}, 32'h2FF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
